mmio_timer: RTL and testbench
=============================

Name: mmio_timer

Overview:
- Memory-mapped countdown timer on the CPU's I/O bus, alongside the LED register (0x100) and switch port (0x140).
- It consumes the CPU's mem_cmd, mem_addr and write data. It returns read data plus a select flag, which the CPU's memory-data mux uses the same way as the switch path.
- It provides a prescaled 16-bit down-counter with one-shot and auto-reload modes, a sticky expiry flag and an interrupt-level output.

Parameters:
- data_width, 16, bus data width; COUNT and LOAD are this wide.
- base_addr, 9'h180, address of register 0; must be 4-aligned with bit 8 set.
- prescale, 4, clk cycles per count tick; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- mem_cmd  input  2  bus command: 2'b01 MWRITE, 2'b11 MREAD, other values idle.
- mem_addr  input  9  bus address.
- din  input  data_width  write data (CPU datapath out).
- dout  output  data_width  read data; 0 when not selected.
- dout_en  output  1  high when MREAD hits a decoded timer address.
- irq  output  1  expired & irq_en.

Behaviour:
- Register map (offset from base_addr):
  - +0 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - +1 LOAD: reload value.
  - +2 COUNT: current count.
  - +3 STATUS: bit0 expired; other bits read 0.
- Decode: exact match on mem_addr[8:2] == base_addr[8:2]. Any other address gives no register effect and dout_en=0.
- Reads: combinational, same cycle as mem_cmd/mem_addr, zero wait states. Reads have no side effects.
- Writes: take effect at the clk edge on which mem_cmd==MWRITE with a decoded address.
  - CTRL: loads bits [2:0] and clears the prescaler.
  - LOAD: loads LOAD and also COUNT; clears the prescaler.
  - COUNT: loads COUNT; clears the prescaler.
  - STATUS: write-1-to-clear on bit0.
- Reset values: CTRL=0, LOAD=0, COUNT=0, STATUS=0, prescaler=0, state=IDLE. The outputs therefore reset to dout=0, dout_en=0, irq=0.
- Prescaler:
  - Counts 0..prescale-1 while state==RUN; holds at 0 otherwise.
  - tick asserts on the cycle the prescaler equals prescale-1, then it wraps to 0.
  - With prescale=1, tick asserts every RUN cycle.
- States:
  - IDLE: CTRL.enable==0.
  - RUN: enabled and counting.
  - DONE: one-shot expired; enable was auto-cleared.
- Transitions:
  - IDLE->RUN: write CTRL with bit0=1.
  - RUN->IDLE: write CTRL with bit0=0.
  - RUN->DONE: expiry with auto_reload=0. CTRL.enable is cleared by hardware in the same edge.
  - DONE->RUN: write CTRL with bit0=1.
  - DONE->IDLE: any other write to CTRL.
- On tick in RUN:
  - COUNT!=0: COUNT <= COUNT-1.
  - COUNT==0 (expiry): STATUS.expired <= 1. If auto_reload, COUNT <= LOAD and stay in RUN; else COUNT stays 0 and go to DONE.
- Period: auto-reload period is (LOAD+1)*prescale cycles. LOAD=0 with auto_reload gives expiry every prescale cycles.
- Arithmetic: unsigned, modulo 2^data_width. There is no underflow because 0 is the expiry state.
- Simultaneous events:
  - A bus write to COUNT or LOAD on a tick cycle wins; the tick is discarded.
  - Expiry and a STATUS W1C on the same edge: the set wins, so expired=1.
  - A CTRL write on an expiry edge: the written value wins, but expired is still set.
- irq: combinational from registered state, so it asserts the cycle after the expiry edge. It stays high until expired is cleared or irq_en is written 0.
- Reset mid-count returns everything to its reset values on the next edge regardless of bus activity.

Optional Feature:
- Macro: MMIO_TIMER_CAPTURE_EN.
- Defined:
  - Adds a CAPTURE register at base_addr+4.
  - Decode extends to that single address (exact 9-bit compare added).
  - On each expiry, CAPTURE <= the number of ticks since the previous expiry or since entering RUN, saturating at all-ones.
  - CAPTURE is read-only (writes are ignored) and resets to 0.
- Undefined: base_addr+4 is not decoded (dout_en=0, reads 0) and no capture logic is built.

Test Plan:
- Reset, then MREAD 0x180..0x183 -> dout=0 and dout_en=1 each. MREAD 0x184 (macro off) -> dout_en=0. MREAD 0x140 -> dout_en=0.
- prescale=4, write LOAD=3, CTRL=3'b001 -> COUNT reads 3,2,1,0 at 4-cycle steps. On the next tick expired=1, state DONE and CTRL reads 0. irq stays 0.
- prescale=4, LOAD=2, CTRL=3'b111 -> expiry every 12 cycles. COUNT reloads to 2. irq rises 1 cycle after the first expiry. Writing STATUS=1 drops irq the next cycle, and irq reasserts at the next expiry.
- Write COUNT=16'h0005 on the same edge as a tick -> COUNT reads 5, not 4. STATUS W1C on an expiry edge -> expired reads 1.
- Assert reset for one cycle while in RUN with COUNT=16'h1234 -> all registers read 0, state IDLE, irq=0, and no further decrements.
- Macro on, prescale=2, LOAD=7, auto_reload -> CAPTURE reads 8 after the second expiry. A write to 0x184 leaves it unchanged.

Source files
------------

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: CPU I/O bus slice seen by the memory-mapped timer.
//   mem_cmd  : 2'b01 write, 2'b11 read, anything else idle
//   mem_addr : 9-bit I/O address
//   din      : write data from the CPU datapath
//   dout     : read data back to the CPU memory-data mux (0 when not selected)
//   dout_en  : select flag, high when a read hits a timer register
// Modports: master = CPU side, slave = timer side.
interface mmio_timer_if #(
  parameter int data_width = 16
);
  logic [1:0]            mem_cmd;
  logic [8:0]            mem_addr;
  logic [data_width-1:0] din;
  logic [data_width-1:0] dout;
  logic                  dout_en;

  modport master (output mem_cmd, output mem_addr, output din,
                  input  dout,    input  dout_en);
  modport slave  (input  mem_cmd, input  mem_addr, input  din,
                  output dout,    output dout_en);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 16-bit countdown timer with one-shot and
// auto-reload modes, a sticky expiry flag and a level interrupt.
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high
//   bus     : mmio_timer_if.slave (mem_cmd, mem_addr, din in; dout, dout_en out)
//   irq     : expired & irq_en
// Registers (offset from base_addr): +0 CTRL {irq_en,auto_reload,enable},
// +1 LOAD, +2 COUNT, +3 STATUS {expired}.
// Optional build macro MMIO_TIMER_CAPTURE_EN adds a read-only CAPTURE register
// at base_addr+4 holding the tick count of the last expiry interval.
module mmio_timer #(
  parameter int         data_width = 16,
  parameter logic [8:0] base_addr  = 9'h180,
  parameter int         prescale   = 4
) (
  input  logic         clk,
  input  logic         reset,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  localparam logic [1:0]            CMD_WRITE  = 2'b01;
  localparam logic [1:0]            CMD_READ   = 2'b11;
  localparam logic [7:0]            PRESC_LAST = 8'(prescale - 1);
  localparam logic [data_width-1:0] ZERO       = {data_width{1'b0}};
  localparam logic [data_width-1:0] ONE        = {{(data_width-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                state_r, state_s;
  logic                  ctrl_en_r, ctrl_en_s;
  logic                  ctrl_auto_r, ctrl_auto_s;
  logic                  ctrl_irq_en_r, ctrl_irq_en_s;
  logic [data_width-1:0] load_r, load_s;
  logic [data_width-1:0] count_r, count_s;
  logic                  expired_r, expired_s;
  logic [7:0]            presc_r, presc_s;

  logic       hit_s, wr_s, rd_s;
  logic [1:0] offset_s;
  logic       wr_ctrl_s, wr_load_s, wr_count_s, wr_status_s;
  logic       tick_s, tick_eff_s, expiry_s;

  assign hit_s       = (bus.mem_addr[8:2] == base_addr[8:2]);
  assign offset_s    = bus.mem_addr[1:0];
  assign wr_s        = (bus.mem_cmd == CMD_WRITE) && hit_s;
  assign rd_s        = (bus.mem_cmd == CMD_READ) && hit_s;
  assign wr_ctrl_s   = wr_s && (offset_s == 2'd0);
  assign wr_load_s   = wr_s && (offset_s == 2'd1);
  assign wr_count_s  = wr_s && (offset_s == 2'd2);
  assign wr_status_s = wr_s && (offset_s == 2'd3);

  assign tick_s      = (state_r == RUN) && (presc_r == PRESC_LAST);
  // A bus write to LOAD or COUNT swallows a coincident tick entirely.
  assign tick_eff_s  = tick_s && !wr_load_s && !wr_count_s;
  assign expiry_s    = tick_eff_s && (count_r == ZERO);

  // Level interrupt straight from registered state.
  assign irq = expired_r && ctrl_irq_en_r;

  // Next-state: FSM, prescaler, counter, then bus writes which take priority.
  always_comb begin
    state_s       = state_r;
    ctrl_en_s     = ctrl_en_r;
    ctrl_auto_s   = ctrl_auto_r;
    ctrl_irq_en_s = ctrl_irq_en_r;
    load_s        = load_r;
    count_s       = count_r;
    presc_s       = presc_r;

    if (state_r == RUN) begin
      presc_s = tick_s ? 8'd0 : (presc_r + 8'd1);
    end else begin
      presc_s = 8'd0;
    end

    if (tick_eff_s) begin
      if (count_r != ZERO) begin
        count_s = count_r - ONE;
      end else if (ctrl_auto_r) begin
        count_s = load_r;
      end else begin
        // One-shot expiry: COUNT stays 0 and hardware drops enable.
        ctrl_en_s = 1'b0;
        state_s   = DONE;
      end
    end else begin
      count_s = count_r;
    end

    if (wr_s) begin
      case (offset_s)
        2'd0: begin
          ctrl_en_s     = bus.din[0];
          ctrl_auto_s   = bus.din[1];
          ctrl_irq_en_s = bus.din[2];
          state_s       = bus.din[0] ? RUN : IDLE;
          presc_s       = 8'd0;
        end
        2'd1: begin
          load_s  = bus.din;
          count_s = bus.din;
          presc_s = 8'd0;
        end
        2'd2: begin
          count_s = bus.din;
          presc_s = 8'd0;
        end
        default: begin
          // STATUS write only affects the expired flag below.
          presc_s = presc_s;
        end
      endcase
    end else begin
      state_s = state_s;
    end

    // W1C on STATUS loses to a simultaneous expiry.
    expired_s = (expired_r && !(wr_status_s && bus.din[0])) || expiry_s;
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      ctrl_en_r     <= 1'b0;
      ctrl_auto_r   <= 1'b0;
      ctrl_irq_en_r <= 1'b0;
      load_r        <= ZERO;
      count_r       <= ZERO;
      expired_r     <= 1'b0;
      presc_r       <= 8'd0;
    end else begin
      state_r       <= state_s;
      ctrl_en_r     <= ctrl_en_s;
      ctrl_auto_r   <= ctrl_auto_s;
      ctrl_irq_en_r <= ctrl_irq_en_s;
      load_r        <= load_s;
      count_r       <= count_s;
      expired_r     <= expired_s;
      presc_r       <= presc_s;
    end
  end

`ifdef MMIO_TIMER_CAPTURE_EN
  localparam logic [data_width-1:0] ONES = {data_width{1'b1}};

  logic [data_width-1:0] tick_cnt_r, tick_cnt_s;
  logic [data_width-1:0] capture_r, capture_s;
  logic [data_width-1:0] tick_cnt_inc_s;
  logic                  cap_hit_s, cap_rd_s, entering_run_s;

  assign cap_hit_s      = (bus.mem_addr == (base_addr + 9'd4));
  assign cap_rd_s       = (bus.mem_cmd == CMD_READ) && cap_hit_s;
  assign entering_run_s = (state_r != RUN) && (state_s == RUN);
  // The expiry tick itself counts towards the interval; saturate at all-ones.
  assign tick_cnt_inc_s = (tick_cnt_r == ONES) ? ONES : (tick_cnt_r + ONE);

  // Interval tick counter and capture of its value on each expiry.
  always_comb begin
    tick_cnt_s = tick_cnt_r;
    capture_s  = capture_r;
    if (entering_run_s) begin
      tick_cnt_s = ZERO;
    end else if (expiry_s) begin
      capture_s  = tick_cnt_inc_s;
      tick_cnt_s = ZERO;
    end else if (tick_eff_s) begin
      tick_cnt_s = tick_cnt_inc_s;
    end else begin
      tick_cnt_s = tick_cnt_r;
    end
  end

  // Capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_r <= ZERO;
      capture_r  <= ZERO;
    end else begin
      tick_cnt_r <= tick_cnt_s;
      capture_r  <= capture_s;
    end
  end
`endif

  // Combinational zero-wait-state read mux; unselected reads return 0.
  always_comb begin
    bus.dout    = ZERO;
    bus.dout_en = 1'b0;
    if (rd_s) begin
      bus.dout_en = 1'b1;
      case (offset_s)
        2'd0:    bus.dout = {{(data_width-3){1'b0}}, ctrl_irq_en_r, ctrl_auto_r, ctrl_en_r};
        2'd1:    bus.dout = load_r;
        2'd2:    bus.dout = count_r;
        2'd3:    bus.dout = {{(data_width-1){1'b0}}, expired_r};
        default: bus.dout = ZERO;
      endcase
`ifdef MMIO_TIMER_CAPTURE_EN
    end else if (cap_rd_s) begin
      bus.dout_en = 1'b1;
      bus.dout    = capture_r;
`endif
    end else begin
      bus.dout_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed self-checking bench for mmio_timer (prescale=4).
// A vector table covers reset values, decode and register access; hand-written
// sequences cover one-shot, auto-reload/irq, simultaneous events, mid-run reset
// and, when MMIO_TIMER_CAPTURE_EN is defined, the CAPTURE register.
module tb_mmio_timer;

  localparam logic [1:0] MW = 2'b01;
  localparam logic [1:0] MR = 2'b11;
  localparam logic [1:0] MI = 2'b00;

  logic clk = 1'b0;
  logic reset;
  logic irq;

  always #5 clk = ~clk;

  mmio_timer_if #(.data_width(16)) bus ();

  mmio_timer #(.data_width(16), .base_addr(9'h180), .prescale(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_dout;
    logic        exp_en;
  } vec_t;

  vec_t vecs[20];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write takes effect at the next rising edge; returns 1 ns after it.
  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    bus.mem_cmd  = MW;
    bus.mem_addr = a;
    bus.din      = d;
    @(posedge clk);
    #1;
    bus.mem_cmd  = MI;
  endtask

  // Combinational read of a decoded register, no clock consumed.
  task automatic rd(input string name, input logic [8:0] a, input logic [15:0] exp);
    bus.mem_cmd  = MR;
    bus.mem_addr = a;
    #1;
    chk(name, {15'd0, bus.dout_en, bus.dout}, {15'd0, 1'b1, exp});
    bus.mem_cmd  = MI;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{MR,    9'h180, 16'h0000, 16'h0000, 1'b1};
    vecs[1]  = '{MR,    9'h181, 16'h0000, 16'h0000, 1'b1};
    vecs[2]  = '{MR,    9'h182, 16'h0000, 16'h0000, 1'b1};
    vecs[3]  = '{MR,    9'h183, 16'h0000, 16'h0000, 1'b1};
`ifdef MMIO_TIMER_CAPTURE_EN
    vecs[4]  = '{MR,    9'h184, 16'h0000, 16'h0000, 1'b1};
`else
    vecs[4]  = '{MR,    9'h184, 16'h0000, 16'h0000, 1'b0};
`endif
    vecs[5]  = '{MR,    9'h140, 16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{2'b10, 9'h182, 16'h0000, 16'h0000, 1'b0};
    vecs[7]  = '{MI,    9'h180, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{MR,    9'h1C0, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{MR,    9'h080, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{MW,    9'h181, 16'hABCD, 16'h0000, 1'b0};
    vecs[11] = '{MR,    9'h181, 16'h0000, 16'hABCD, 1'b1};
    vecs[12] = '{MR,    9'h182, 16'h0000, 16'hABCD, 1'b1};
    vecs[13] = '{MW,    9'h180, 16'hFFF6, 16'h0000, 1'b0};
    vecs[14] = '{MR,    9'h180, 16'h0000, 16'h0006, 1'b1};
    vecs[15] = '{MW,    9'h183, 16'hFFFF, 16'h0000, 1'b0};
    vecs[16] = '{MR,    9'h183, 16'h0000, 16'h0000, 1'b1};
    vecs[17] = '{MW,    9'h180, 16'h0000, 16'h0000, 1'b0};
    vecs[18] = '{MR,    9'h180, 16'h0000, 16'h0000, 1'b1};
    vecs[19] = '{MR,    9'h182, 16'h0000, 16'hABCD, 1'b1};

    reset        = 1'b1;
    bus.mem_cmd  = MI;
    bus.mem_addr = 9'h000;
    bus.din      = 16'h0000;
    idle(2);
    reset = 1'b0;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_idle_en", {15'd0, bus.dout_en, bus.dout}, 32'd0);

    // Table: reset values, decode and plain register access.
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].cmd == MW) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        bus.mem_cmd  = vecs[i].cmd;
        bus.mem_addr = vecs[i].addr;
        bus.din      = vecs[i].data;
        #1;
        chk($sformatf("vec%0d", i), {15'd0, bus.dout_en, bus.dout},
            {15'd0, vecs[i].exp_en, vecs[i].exp_dout});
        bus.mem_cmd  = MI;
      end
    end

    // One-shot: LOAD=3, enable at edge E1; ticks at E5, E9, E13, expiry at E17.
    wr(9'h181, 16'd3);
    wr(9'h180, 16'h0001);
    rd("os_cnt3a", 9'h182, 16'd3);
    idle(3);
    rd("os_cnt3b", 9'h182, 16'd3);
    idle(1);
    rd("os_cnt2", 9'h182, 16'd2);
    idle(4);
    rd("os_cnt1", 9'h182, 16'd1);
    idle(4);
    rd("os_cnt0", 9'h182, 16'd0);
    idle(3);
    rd("os_stat_pre", 9'h183, 16'd0);
    rd("os_ctrl_pre", 9'h180, 16'd1);
    idle(1);
    rd("os_stat_exp", 9'h183, 16'd1);
    rd("os_ctrl_done", 9'h180, 16'd0);
    chk("os_irq", {31'd0, irq}, 32'd0);
    idle(8);
    rd("os_cnt_hold", 9'h182, 16'd0);

    // Auto-reload with irq: LOAD=2, period 12 cycles, expiry at E13 and E25.
    wr(9'h183, 16'h0001);
    rd("ar_stat_clr", 9'h183, 16'd0);
    wr(9'h181, 16'd2);
    wr(9'h180, 16'h0007);
    idle(11);
    chk("ar_irq_pre", {31'd0, irq}, 32'd0);
    rd("ar_cnt_pre", 9'h182, 16'd0);
    idle(1);
    chk("ar_irq_up", {31'd0, irq}, 32'd1);
    rd("ar_cnt_reload", 9'h182, 16'd2);
    rd("ar_stat", 9'h183, 16'd1);
    wr(9'h183, 16'h0001);
    chk("ar_irq_drop", {31'd0, irq}, 32'd0);
    idle(10);
    chk("ar_irq_low", {31'd0, irq}, 32'd0);
    idle(1);
    chk("ar_irq_again", {31'd0, irq}, 32'd1);

    // COUNT write on the tick edge E29 wins; W1C on expiry edge E53 loses.
    idle(3);
    wr(9'h182, 16'h0005);
    rd("sim_cnt_wr", 9'h182, 16'd5);
    wr(9'h183, 16'h0001);
    rd("sim_stat_clr", 9'h183, 16'd0);
    idle(22);
    rd("sim_cnt0", 9'h182, 16'd0);
    wr(9'h183, 16'h0001);
    rd("sim_stat_set", 9'h183, 16'd1);
    rd("sim_cnt_reload", 9'h182, 16'd2);
    chk("sim_irq", {31'd0, irq}, 32'd1);

    // Reset mid-run with a competing bus write.
    wr(9'h182, 16'h1234);
    idle(2);
    reset        = 1'b1;
    bus.mem_cmd  = MW;
    bus.mem_addr = 9'h181;
    bus.din      = 16'hFFFF;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.mem_cmd = MI;
    chk("mr_irq", {31'd0, irq}, 32'd0);
    rd("mr_ctrl", 9'h180, 16'd0);
    rd("mr_load", 9'h181, 16'd0);
    rd("mr_cnt", 9'h182, 16'd0);
    rd("mr_stat", 9'h183, 16'd0);
    idle(20);
    rd("mr_cnt_hold", 9'h182, 16'd0);
    rd("mr_ctrl_hold", 9'h180, 16'd0);

`ifdef MMIO_TIMER_CAPTURE_EN
    // LOAD=7 auto-reload: 8 ticks per interval, expiries at E33 and E65.
    wr(9'h181, 16'd7);
    wr(9'h180, 16'h0003);
    idle(32);
    rd("cap_first", 9'h184, 16'd8);
    idle(32);
    rd("cap_second", 9'h184, 16'd8);
    wr(9'h184, 16'h0000);
    rd("cap_ro", 9'h184, 16'd8);
`else
    wr(9'h184, 16'hFFFF);
    bus.mem_cmd  = MR;
    bus.mem_addr = 9'h184;
    #1;
    chk("nocap_rd", {15'd0, bus.dout_en, bus.dout}, 32'd0);
    bus.mem_cmd  = MI;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
